// File: rtl/tile_local_arb_if.sv
// Stream bundle between the requesters, the local arbiter and the switch local input.
// slave is the arbiter's view; master is the view of whatever drives requesters and switch ready.
interface tile_local_arb_if #(
    parameter int BW    = 32,
    parameter int BWB   = BW / 8,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]     req_en;
    logic [N_REQ-1:0]     s_TVALID;
    logic [N_REQ*BW-1:0]  s_TDATA;
    logic [N_REQ*BWB-1:0] s_TKEEP;
    logic [N_REQ-1:0]     s_TLAST;
    logic [N_REQ-1:0]     s_TREADY;
    logic                 m_TVALID;
    logic [BW-1:0]        m_TDATA;
    logic [BWB-1:0]       m_TKEEP;
    logic                 m_TLAST;
    logic                 m_TREADY;
    logic [2:0]           grant_id;
    logic                 busy;
    logic [15:0]          pkt_count;
    logic                 len_err;

    modport slave (
        input  req_en, s_TVALID, s_TDATA, s_TKEEP, s_TLAST, m_TREADY,
        output s_TREADY, m_TVALID, m_TDATA, m_TKEEP, m_TLAST,
        output grant_id, busy, pkt_count, len_err
    );

    modport master (
        output req_en, s_TVALID, s_TDATA, s_TKEEP, s_TLAST, m_TREADY,
        input  s_TREADY, m_TVALID, m_TDATA, m_TKEEP, m_TLAST,
        input  grant_id, busy, pkt_count, len_err
    );
endinterface

// File: rtl/tile_local_arb.sv
// Packet-granular round-robin arbiter merging N_REQ requester streams into the switch local input.
// Ownership is taken in IDLE and held for a whole packet; one idle cycle separates packets.
module tile_local_arb #(
    parameter int BW        = 32,
    parameter int BWB       = BW / 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BEATS = 256
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_low,
    tile_local_arb_if.slave  bus
);
    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  XFER = 1'b1;
    localparam int unsigned NR   = N_REQ;
    localparam int          CW   = $clog2(MAX_BEATS + 1);

    logic [0:0]     r_state;
    logic [2:0]     r_last_grant;
    logic [2:0]     r_grant_id;
    logic           r_busy;
    logic [15:0]    r_pkt_count;
    logic           r_len_err;
    logic [CW-1:0]  r_beat_cnt;

    logic [7:0]     w_elig;
    logic           w_any;
    logic [2:0]     w_next;
    logic [2:0]     w_cand;
    logic           w_hs;

    assign w_elig = 8'(bus.s_TVALID & bus.req_en);

    // Rotating search starting just above the previous owner.
    always_comb begin
        w_any  = 1'b0;
        w_next = '0;
        w_cand = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            w_cand = 3'((32'(r_last_grant) + k) % NR);
            if (!w_any && w_elig[w_cand]) begin
                w_any  = 1'b1;
                w_next = w_cand;
            end
        end
    end

    always_comb begin
        bus.m_TVALID = 1'b0;
        bus.m_TDATA  = '0;
        bus.m_TKEEP  = '0;
        bus.m_TLAST  = 1'b0;
        bus.s_TREADY = '0;
        if (r_state == XFER) begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (r_grant_id == 3'(i)) begin
                    bus.m_TVALID    = bus.s_TVALID[i];
                    bus.m_TDATA     = bus.s_TDATA[i*BW +: BW];
                    bus.m_TKEEP     = bus.s_TKEEP[i*BWB +: BWB];
                    bus.m_TLAST     = bus.s_TLAST[i];
                    bus.s_TREADY[i] = bus.m_TREADY;
                end
            end
        end
    end

    assign w_hs = (r_state == XFER) && bus.m_TVALID && bus.m_TREADY;

    always_ff @(posedge clk_line) begin
        if (!clk_line_rst_low) begin
            r_state      <= IDLE;
            r_last_grant <= 3'(N_REQ - 1);
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_pkt_count  <= '0;
            r_len_err    <= 1'b0;
            r_beat_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (w_any) begin
                r_grant_id <= w_next;
                r_busy     <= 1'b1;
                r_state    <= XFER;
            end
        end else if (w_hs) begin
            // Counter parks at MAX_BEATS; any further beat marks the overrun.
            if (r_beat_cnt == CW'(MAX_BEATS)) begin
                r_len_err <= 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (bus.m_TLAST) begin
                r_last_grant <= r_grant_id;
                r_pkt_count  <= r_pkt_count + 16'd1;
                r_beat_cnt   <= '0;
                r_busy       <= 1'b0;
                r_state      <= IDLE;
            end
        end
    end

    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = r_busy;
    assign bus.pkt_count = r_pkt_count;
    assign bus.len_err   = r_len_err;
endmodule

// File: tb/tb_tile_local_arb.sv
// Directed bench for tile_local_arb: a cycle table for arbitration order and masking,
// then hand-written sequences for stalls, length overrun and mid-packet reset.
module tb_tile_local_arb;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_local_arb_if #(.BW(32), .BWB(4), .N_REQ(4)) bus ();

    tile_local_arb #(.BW(32), .BWB(4), .N_REQ(4), .MAX_BEATS(4)) dut (
        .clk_line         (clk),
        .clk_line_rst_low (rst_n),
        .bus              (bus)
    );

    typedef struct packed {
        logic [3:0]  sready;
        logic        mvalid;
        logic [31:0] mdata;
        logic [3:0]  mkeep;
        logic        mlast;
        logic [2:0]  gid;
        logic        busy;
        logic [15:0] pkt;
        logic        lerr;
    } out_t;

    typedef struct {
        logic [3:0] en;
        logic [3:0] valid;
        logic [3:0] last;
        logic       rdy;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic out_t idle(logic [2:0] gid, logic [15:0] pkt, logic lerr);
        return '{4'h0, 1'b0, 32'h0, 4'h0, 1'b0, gid, 1'b0, pkt, lerr};
    endfunction

    function automatic out_t xfer(logic [3:0] sready, logic [31:0] d, logic [3:0] k, logic ml,
                                  logic [2:0] gid, logic [15:0] pkt, logic lerr);
        return '{sready, 1'b1, d, k, ml, gid, 1'b1, pkt, lerr};
    endfunction

    function automatic out_t sample();
        return '{bus.s_TREADY, bus.m_TVALID, bus.m_TDATA, bus.m_TKEEP, bus.m_TLAST,
                 bus.grant_id, bus.busy, bus.pkt_count, bus.len_err};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = sample();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got sready=%h mv=%b d=%h k=%h ml=%b gid=%0d busy=%b pkt=%0d le=%b, required sready=%h mv=%b d=%h k=%h ml=%b gid=%0d busy=%b pkt=%0d le=%b",
                     name, got.sready, got.mvalid, got.mdata, got.mkeep, got.mlast, got.gid,
                     got.busy, got.pkt, got.lerr, exp.sready, exp.mvalid, exp.mdata, exp.mkeep,
                     exp.mlast, exp.gid, exp.busy, exp.pkt, exp.lerr);
        end
    endtask

    // Requester i presents {C0, i, 00, tag} with keep bit i set.
    task automatic drive(input logic [3:0] en, input logic [3:0] valid, input logic [3:0] last,
                         input logic rdy, input logic [7:0] tag);
        bus.req_en   = en;
        bus.s_TVALID = valid;
        bus.s_TLAST  = last;
        bus.m_TREADY = rdy;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.s_TDATA[i*32 +: 32] = {8'hC0, 8'(i), 8'h00, tag};
            bus.s_TKEEP[i*4 +: 4]   = 4'(1 << i);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic [3:0] v, input logic [3:0] l,
                       input logic rdy, input out_t e);
        vecs.push_back('{en, v, l, rdy, e});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic rdy_pat[6];
        int   hs;
        int   b;

        // Four simultaneous 3-beat packets: grants 0,1,2,3 with one idle between.
        add(4'hF, 4'hF, 4'h0, 1'b1, idle(0, 0, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h1, 32'hC000_0001, 4'h1, 0, 0, 0, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h1, 32'hC000_0002, 4'h1, 0, 0, 0, 0));
        add(4'hF, 4'hF, 4'hF, 1'b1, xfer(4'h1, 32'hC000_0003, 4'h1, 1, 0, 0, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, idle(0, 1, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h2, 32'hC001_0005, 4'h2, 0, 1, 1, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h2, 32'hC001_0006, 4'h2, 0, 1, 1, 0));
        add(4'hF, 4'hF, 4'hF, 1'b1, xfer(4'h2, 32'hC001_0007, 4'h2, 1, 1, 1, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, idle(1, 2, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h4, 32'hC002_0009, 4'h4, 0, 2, 2, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h4, 32'hC002_000A, 4'h4, 0, 2, 2, 0));
        add(4'hF, 4'hF, 4'hF, 1'b1, xfer(4'h4, 32'hC002_000B, 4'h4, 1, 2, 2, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, idle(2, 3, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h8, 32'hC003_000D, 4'h8, 0, 3, 3, 0));
        add(4'hF, 4'hF, 4'h0, 1'b1, xfer(4'h8, 32'hC003_000E, 4'h8, 0, 3, 3, 0));
        add(4'hF, 4'hF, 4'hF, 1'b1, xfer(4'h8, 32'hC003_000F, 4'h8, 1, 3, 3, 0));
        add(4'hF, 4'h0, 4'h0, 1'b1, idle(3, 4, 0));
        // req_en=1011 masks requester 2; dropping req_en[3] mid-packet changes nothing.
        add(4'hB, 4'hC, 4'h0, 1'b1, idle(3, 4, 0));
        add(4'hB, 4'hC, 4'h0, 1'b1, xfer(4'h8, 32'hC003_0012, 4'h8, 0, 3, 4, 0));
        add(4'h3, 4'hC, 4'h0, 1'b1, xfer(4'h8, 32'hC003_0013, 4'h8, 0, 3, 4, 0));
        add(4'h3, 4'hC, 4'h8, 1'b1, xfer(4'h8, 32'hC003_0014, 4'h8, 1, 3, 4, 0));
        // Single-beat packet from requester 1 leaves last_grant=1.
        add(4'hF, 4'h2, 4'h2, 1'b1, idle(3, 5, 0));
        add(4'hF, 4'h2, 4'h2, 1'b1, xfer(4'h2, 32'hC001_0016, 4'h2, 1, 1, 5, 0));
        // Requesters 0 and 3 with last_grant=1: 3 wins, then 0.
        add(4'hF, 4'h9, 4'h0, 1'b1, idle(1, 6, 0));
        add(4'hF, 4'h9, 4'h9, 1'b1, xfer(4'h8, 32'hC003_0018, 4'h8, 1, 3, 6, 0));
        add(4'hF, 4'h9, 4'h0, 1'b1, idle(3, 7, 0));
        add(4'hF, 4'h9, 4'h9, 1'b1, xfer(4'h1, 32'hC000_001A, 4'h1, 1, 0, 7, 0));
        add(4'hF, 4'h0, 4'h0, 1'b1, idle(0, 8, 0));

        drive(4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].valid, vecs[i].last, vecs[i].rdy, 8'(i));
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
            next_cycle();
        end

        // Stalled 4-beat packet from requester 1, ready pattern 1,0,0,1,1,1.
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b1; rdy_pat[5] = 1'b1;
        drive(4'hF, 4'h2, 4'h0, 1'b1, 8'd1);
        #1;
        check("stall_idle", idle(0, 8, 0));
        next_cycle();
        b  = 1;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            drive(4'hF, 4'h2, (b == 4) ? 4'h2 : 4'h0, rdy_pat[c], 8'(b));
            #1;
            check($sformatf("stall_cyc%0d", c),
                  xfer(rdy_pat[c] ? 4'h2 : 4'h0, {8'hC0, 8'h01, 8'h00, 8'(b)}, 4'h2,
                       b == 4, 1, 8, 0));
            if (bus.m_TVALID && bus.m_TREADY) begin
                hs++;
                b++;
            end
            next_cycle();
        end
        n_tests++;
        if (hs != 4) begin
            n_fail++;
            $display("FAIL stall_handshakes: got %0d, required 4", hs);
        end
        drive(4'hF, 4'h0, 4'h0, 1'b1, 8'd0);
        #1;
        check("stall_done", idle(1, 9, 0));
        next_cycle();

        // 5-beat packet against MAX_BEATS=4: all beats forwarded, len_err after the 5th.
        drive(4'hF, 4'h4, 4'h0, 1'b1, 8'd1);
        #1;
        check("len_idle", idle(1, 9, 0));
        next_cycle();
        for (int k = 1; k <= 5; k++) begin
            drive(4'hF, 4'h4, (k == 5) ? 4'h4 : 4'h0, 1'b1, 8'(k));
            #1;
            check($sformatf("len_beat%0d", k),
                  xfer(4'h4, {8'hC0, 8'h02, 8'h00, 8'(k)}, 4'h4, k == 5, 2, 9, 0));
            next_cycle();
        end
        drive(4'hF, 4'hF, 4'h0, 1'b1, 8'd1);
        #1;
        check("len_err_set", idle(2, 10, 1));
        next_cycle();

        // Reset on beat 2 of requester 3's packet.
        drive(4'hF, 4'hF, 4'h0, 1'b1, 8'd1);
        #1;
        check("rst_beat1", xfer(4'h8, 32'hC003_0001, 4'h8, 0, 3, 10, 1));
        next_cycle();
        drive(4'hF, 4'hF, 4'h0, 1'b1, 8'd2);
        #1;
        check("rst_beat2", xfer(4'h8, 32'hC003_0002, 4'h8, 0, 3, 10, 1));
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        drive(4'hF, 4'hF, 4'h0, 1'b1, 8'd3);
        #1;
        check("rst_after", idle(0, 0, 0));
        next_cycle();
        drive(4'hF, 4'hF, 4'h0, 1'b1, 8'd4);
        #1;
        check("rst_regrant", xfer(4'h1, 32'hC000_0004, 4'h1, 0, 0, 0, 0));
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
